sw_event_poller: RTL and testbench
==================================

# sw_event_poller

Polling controller for the 10-bit switch PIO's Avalon-MM slave port (data register at address 0, edge-capture register at address 3; a write to address 3 clears all capture bits). It periodically reads the edge-capture register. When any bit is set, it reads the current switch levels, clears the capture register, and pushes a `{level, capture}` event into a small first-word-fall-through FIFO with an interrupt output. It sits between the switch PIO and the consumer logic (CPU-facing event register or local control FSM), so consumers never handle PIO read latency or clear ordering.

## Interface
- `POLL_DIV`, 50000: clock cycles between poll starts; legal range ≥ 8.
- `WIDTH`, 10: switch/capture width; matches the PIO.
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, ≥ 2.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: 1 = polling active.
- `avm_address` out 2: PIO register address.
- `avm_chipselect` out 1: PIO select.
- `avm_write_n` out 1: active-low write strobe.
- `avm_writedata` out 32: always 0.
- `avm_readdata` in 32: PIO read data; registered in the PIO, so it is valid the cycle after the address is driven.
- `evt_valid` out 1: FIFO non-empty.
- `evt_ready` in 1: consumer pop; a pop occurs when `evt_valid && evt_ready`.
- `evt_data` out 2*WIDTH: head entry, `{level[WIDTH-1:0], capture[WIDTH-1:0]}`.
- `evt_count` out clog2(FIFO_DEPTH)+1: number of stored entries.
- `overflow` out 1: sticky; set when an event is dropped.
- `ovf_clr` in 1: clears `overflow`.
- `irq` out 1: `evt_valid & enable`.

## Operation
- **Tick counter**
  - Counts 0..POLL_DIV-1 while `enable`=1; held at 0 while `enable`=0.
  - A tick fires when the count equals POLL_DIV-1 and the FSM is in IDLE.
  - A tick arriving while the FSM is busy is dropped, not queued.
- **FSM states** (all Avalon outputs registered):
  - IDLE: bus idle (`chipselect`=0, `write_n`=1, `address`=0). On tick → RD_CAP.
  - RD_CAP: `address`=3, `chipselect`=1, `write_n`=1 → LAT_CAP.
  - LAT_CAP: bus idle. Sample `avm_readdata[WIDTH-1:0]` into `cap_r`. If `cap_r`=0 → IDLE, else → RD_DAT.
  - RD_DAT: `address`=0, `chipselect`=1 → LAT_DAT.
  - LAT_DAT: sample level into `lvl_r` → CLR.
  - CLR: `address`=3, `chipselect`=1, `write_n`=0, `writedata`=0 for exactly one cycle → PUSH.
  - PUSH: write `{lvl_r, cap_r}` into the FIFO → IDLE.
- **Event loss windows**
  - An edge that the PIO captures between the LAT_CAP sample and CLR is lost (3-cycle window). This is an accepted limitation.
  - If the FIFO is full at PUSH with no simultaneous pop, the event is dropped and `overflow` is set. CLR still happens.
- **Disable behaviour:** `enable` falling mid-poll does not abort the poll; the sequence completes to IDLE.
- **FIFO**
  - FWFT: `evt_data` shows the head whenever `evt_valid`=1.
  - Push and pop in the same cycle: both succeed and `evt_count` is unchanged. This holds even when full, because the full check uses the post-pop state.
  - Pointers wrap modulo FIFO_DEPTH.
- **`overflow` flag:** `ovf_clr` has priority over a simultaneous set.

## Timing
- **Reset values**
  - Outputs: `avm_address`=0, `avm_chipselect`=0, `avm_write_n`=1, `avm_writedata`=0, `evt_valid`=0, `evt_data`=0, `evt_count`=0, `overflow`=0, `irq`=0.
  - Internal: FSM in IDLE, tick counter 0.
- **Reset mid-poll:** the FSM returns to IDLE on the next edge, the FIFO is emptied, and no CLR write is issued. Capture bits remain in the PIO and are picked up by the next poll.
- **Cycle sequence**, tick decided in cycle T:
  - RD_CAP in T+1, LAT_CAP in T+2.
  - Empty-capture poll: back in IDLE at T+3.
  - Event poll: RD_DAT in T+3, LAT_DAT in T+4, CLR in T+5, PUSH in T+6. `evt_valid` rises at T+7 if the FIFO was empty.
- **Poll period:** exactly POLL_DIV cycles between RD_CAP cycles while `enable` stays high.
- **Bus strobes:** `avm_chipselect` never asserts in LAT_* or IDLE. `avm_write_n`=0 occurs only in CLR.

## Test plan
- **Basic event:** POLL_DIV=8; the PIO model latches capture=0x005, level=0x005 → one CLR write to address 3 and one event `evt_data`={0x005,0x005}; `irq`=1 until the pop, then 0.
- **No activity:** capture=0 for 10 polls → exactly 10 reads of address 3, no reads of address 0, no writes, `evt_count`=0.
- **Overflow:** FIFO_DEPTH=4, `evt_ready`=0, 6 distinct events → `evt_count`=4, `overflow`=1, all 6 CLR writes seen. Then `ovf_clr` → `overflow`=0.
- **Full with simultaneous pop:** FIFO full, `evt_ready`=1 in the PUSH cycle → `evt_count` stays 4, new entry stored, `overflow` stays 0.
- **Reset mid-poll:** assert `reset` in LAT_DAT → all outputs at reset values next cycle, no address-3 write. The capture bit stays set in the PIO and is reported by the first poll after reset.
- **Disable mid-poll:** drop `enable` in RD_CAP with capture=0x200 → the event is still pushed and `irq`=0 while disabled. Re-enabling raises `irq` with the event still in the FIFO.

Source files
------------

// File: rtl/sw_event_poller.sv
// Polls the switch PIO edge-capture register, clears it, and queues {level, capture}
// events in a first-word-fall-through FIFO for the consumer.
module sw_event_poller #(
  parameter int POLL_DIV   = 50000,
  parameter int WIDTH      = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  output logic [1:0]                    avm_address,
  output logic                          avm_chipselect,
  output logic                          avm_write_n,
  output logic [31:0]                   avm_writedata,
  input  logic [31:0]                   avm_readdata,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [2*WIDTH-1:0]            evt_data,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          irq
);

  localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POLL_DIV - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CAP, S_LAT_CAP, S_RD_DAT, S_LAT_DAT, S_CLR, S_PUSH
  } state_t;

  state_t                 state_q;
  logic [1:0]             addr_q;
  logic                   cs_q;
  logic                   wr_n_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       cap_q, lvl_q;
  logic [2*WIDTH-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         count_q, count_d;
  logic                   ovf_q;
  logic                   tick, pop, push_req, push_ok, drop;
  logic                   unused_rd;

  assign unused_rd = &{1'b0, avm_readdata};

  // Tick counter: free-running while enabled, parked at zero otherwise
  assign tick  = enable && (cnt_q == CNT_MAX) && (state_q == S_IDLE);
  assign cnt_d = (!enable || cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Poll sequencer with registered bus strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 2'd0;
      cs_q    <= 1'b0;
      wr_n_q  <= 1'b1;
    end else begin
      addr_q <= 2'd0;
      cs_q   <= 1'b0;
      wr_n_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_q <= S_RD_CAP;
            addr_q  <= 2'd3;
            cs_q    <= 1'b1;
          end
        end
        S_RD_CAP: state_q <= S_LAT_CAP;
        S_LAT_CAP: begin
          if (avm_readdata[WIDTH-1:0] != '0) begin
            state_q <= S_RD_DAT;
            cs_q    <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RD_DAT: state_q <= S_LAT_DAT;
        S_LAT_DAT: begin
          state_q <= S_CLR;
          addr_q  <= 2'd3;
          cs_q    <= 1'b1;
          wr_n_q  <= 1'b0;
        end
        S_CLR:   state_q <= S_PUSH;
        S_PUSH:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LAT_CAP) cap_q <= avm_readdata[WIDTH-1:0];
    if (state_q == S_LAT_DAT) lvl_q <= avm_readdata[WIDTH-1:0];
  end

  // Event FIFO: fullness is judged after this cycle's pop
  assign pop      = (count_q != '0) && evt_ready;
  assign push_req = (state_q == S_PUSH);
  assign push_ok  = push_req && ((count_q != FULL_CNT) || pop);
  assign drop     = push_req && !push_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (ovf_clr)   ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {lvl_q, cap_q};
  end

  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wr_n_q;
  assign avm_writedata  = 32'd0;
  assign evt_valid      = (count_q != '0);
  assign evt_data       = evt_valid ? mem_q[rd_ptr_q] : '0;
  assign evt_count      = count_q;
  assign overflow       = ovf_q;
  assign irq            = evt_valid & enable;

endmodule

// File: tb/tb_sw_event_poller.sv
// Directed bench for sw_event_poller: switch PIO model, poll-timeline reference model,
// per-cycle output comparison and hand-computed spot checks.
module tb_sw_event_poller;
  localparam int PD = 8;
  localparam int W  = 10;
  localparam int D  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        evt_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_chipselect, avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] pio_rd = '0;
  logic        evt_valid;
  logic [2*W-1:0] evt_data;
  logic [2:0]  evt_count;
  logic        overflow, irq;

  logic [W-1:0] pio_cap = '0;
  logic [W-1:0] pio_lvl = '0;
  logic [W-1:0] edge_in = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rd3 = 0, n_rd0 = 0, n_wr = 0, n_wr3 = 0;

  int           m_cnt = 0;
  int           m_age = -1;
  logic [W-1:0] m_cap = '0, m_lvl = '0;
  logic         m_ovf = 1'b0;
  logic [2*W-1:0] mq[$];

  always #5 clk = ~clk;

  sw_event_poller #(.POLL_DIV(PD), .WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(pio_rd),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_count(evt_count), .overflow(overflow), .ovf_clr(ovf_clr), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // PIO model plus reference model of the poll timeline and event queue
  initial begin : model
    bit pop, drop;
    int nxt;
    forever begin
      @(posedge clk);
      if (avm_chipselect && avm_write_n)
        pio_rd <= (avm_address == 2'd3) ? {22'b0, pio_cap} :
                  (avm_address == 2'd0) ? {22'b0, pio_lvl} : 32'd0;
      pio_cap <= ((avm_chipselect && !avm_write_n && avm_address == 2'd3) ? '0 : pio_cap) | edge_in;
      if (avm_chipselect && avm_write_n && avm_address == 2'd3) n_rd3++;
      if (avm_chipselect && avm_write_n && avm_address == 2'd0) n_rd0++;
      if (avm_chipselect && !avm_write_n) n_wr++;
      if (avm_chipselect && !avm_write_n && avm_address == 2'd3) n_wr3++;

      if (reset) begin
        m_cnt = 0;
        m_age = -1;
        mq.delete();
        m_ovf = 1'b0;
      end else begin
        pop  = (mq.size() != 0) && evt_ready;
        drop = 1'b0;
        if (pop) void'(mq.pop_front());
        if (m_age == 1) m_cap = pio_cap;
        if (m_age == 3) m_lvl = pio_lvl;
        if (m_age == 6) begin
          if (mq.size() < D) mq.push_back({m_lvl, m_cap});
          else drop = 1'b1;
        end
        if (m_age < 0) nxt = (enable && m_cnt == PD - 1) ? 1 : -1;
        else if ((m_age == 2 && m_cap == '0) || m_age == 6) nxt = -1;
        else nxt = m_age + 1;
        m_age = nxt;
        m_ovf = ovf_clr ? 1'b0 : (drop ? 1'b1 : m_ovf);
        m_cnt = !enable ? 0 : ((m_cnt == PD - 1) ? 0 : m_cnt + 1);
      end
    end
  end

  initial begin : compare
    logic [1:0]     ea;
    logic           ecs, ewn;
    logic [2*W-1:0] ed;
    forever begin
      @(negedge clk);
      ecs = (m_age == 1) || (m_age == 3) || (m_age == 5);
      ea  = ((m_age == 1) || (m_age == 5)) ? 2'd3 : 2'd0;
      ewn = (m_age != 5);
      ed  = (mq.size() != 0) ? mq[0] : '0;
      check("cyc_address", 32'(avm_address), 32'(ea));
      check("cyc_chipselect", 32'(avm_chipselect), 32'(ecs));
      check("cyc_write_n", 32'(avm_write_n), 32'(ewn));
      check("cyc_writedata", avm_writedata, 32'd0);
      check("cyc_evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
      check("cyc_evt_data", 32'(evt_data), 32'(ed));
      check("cyc_evt_count", 32'(evt_count), 32'(mq.size()));
      check("cyc_overflow", 32'(overflow), 32'(m_ovf));
      check("cyc_irq", 32'(irq), 32'((mq.size() != 0) && enable));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic inject(input logic [W-1:0] m, input logic [W-1:0] l);
    pio_lvl = l;
    edge_in = m;
    cyc(1);
    edge_in = '0;
  endtask

  task automatic wait_age(input int a, input string nm);
    int i;
    i = 0;
    while (m_age != a && i < 64) begin
      cyc(1);
      i++;
    end
    check(nm, 32'(m_age == a), 32'd1);
  endtask

  task automatic wait_valid(input string nm);
    int i;
    i = 0;
    while (!evt_valid && i < 64) begin
      cyc(1);
      i++;
    end
    check(nm, 32'(evt_valid), 32'd1);
  endtask

  task automatic wait_wr(input int base, input string nm);
    int i;
    i = 0;
    while (n_wr == base && i < 64) begin
      cyc(1);
      i++;
    end
    check(nm, 32'(n_wr - base), 32'd1);
  endtask

  initial begin : stim
    int b_wr, b_wr3, b_rd3, b_rd0;
    cyc(2);
    check("rst_address", 32'(avm_address), 32'd0);
    check("rst_chipselect", 32'(avm_chipselect), 32'd0);
    check("rst_write_n", 32'(avm_write_n), 32'd1);
    check("rst_writedata", avm_writedata, 32'd0);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_data", 32'(evt_data), 32'd0);
    check("rst_evt_count", 32'(evt_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset  = 1'b0;
    enable = 1'b1;

    b_wr = n_wr; b_wr3 = n_wr3;
    inject(10'h005, 10'h005);
    wait_valid("basic_wait");
    check("basic_data", 32'(evt_data), 32'h01405);
    check("basic_irq", 32'(irq), 32'd1);
    cyc(2);
    check("basic_wr3", 32'(n_wr3 - b_wr3), 32'd1);
    check("basic_wr", 32'(n_wr - b_wr), 32'd1);
    check("basic_irq_hold", 32'(irq), 32'd1);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    check("basic_pop_valid", 32'(evt_valid), 32'd0);
    check("basic_pop_irq", 32'(irq), 32'd0);

    b_rd3 = n_rd3; b_rd0 = n_rd0; b_wr = n_wr;
    cyc(80);
    check("idle_rd3", 32'(n_rd3 - b_rd3), 32'd10);
    check("idle_rd0", 32'(n_rd0 - b_rd0), 32'd0);
    check("idle_wr", 32'(n_wr - b_wr), 32'd0);
    check("idle_count", 32'(evt_count), 32'd0);

    b_wr = n_wr;
    for (int k = 0; k < 6; k++) begin
      int bw;
      bw = n_wr;
      inject(10'(1 << k), 10'h3F0 + 10'(k));
      wait_wr(bw, "ovf_clr_write");
    end
    cyc(3);
    check("ovf_count", 32'(evt_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_writes", 32'(n_wr - b_wr), 32'd6);
    check("ovf_head", 32'(evt_data), 32'hFC001);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    inject(10'h00F, 10'h0F0);
    wait_age(6, "fullpop_wait");
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    check("fullpop_count", 32'(evt_count), 32'd4);
    check("fullpop_flag", 32'(overflow), 32'd0);
    check("fullpop_head", 32'(evt_data), 32'hFC402);
    evt_ready = 1'b1;
    cyc(3);
    evt_ready = 1'b0;
    check("fullpop_tail", 32'(evt_data), 32'h3C00F);

    b_wr = n_wr;
    inject(10'h0AA, 10'h155);
    wait_age(4, "rstmid_wait");
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("rstmid_chipselect", 32'(avm_chipselect), 32'd0);
    check("rstmid_address", 32'(avm_address), 32'd0);
    check("rstmid_write_n", 32'(avm_write_n), 32'd1);
    check("rstmid_count", 32'(evt_count), 32'd0);
    check("rstmid_evt_data", 32'(evt_data), 32'd0);
    check("rstmid_irq", 32'(irq), 32'd0);
    check("rstmid_no_clr", 32'(n_wr - b_wr), 32'd0);
    check("rstmid_cap_kept", 32'(pio_cap), 32'h0AA);
    wait_valid("rstmid_repoll");
    check("rstmid_data", 32'(evt_data), 32'h554AA);
    check("rstmid_one_clr", 32'(n_wr - b_wr), 32'd1);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;

    inject(10'h200, 10'h001);
    wait_age(1, "dis_wait");
    enable = 1'b0;
    cyc(10);
    check("dis_valid", 32'(evt_valid), 32'd1);
    check("dis_irq", 32'(irq), 32'd0);
    check("dis_data", 32'(evt_data), 32'h00600);
    check("dis_count", 32'(evt_count), 32'd1);
    enable = 1'b1;
    #1;
    check("dis_reen_irq", 32'(irq), 32'd1);
    cyc(1);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    check("dis_pop_count", 32'(evt_count), 32'd0);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
